// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//   Shared types and default sizing for the FIFO write arbiter slice.
//   state_t     : arbiter FSM states (IDLE = arbitrate, BURST = stream beats)
//   *_DEFAULT   : default producer count, payload width and burst limit
//   ID_W        : producer index width for the default producer count
package fifo_arb_pkg;

    localparam int N_REQ_DEFAULT     = 4;
    localparam int DATA_W_DEFAULT    = 8;
    localparam int MAX_BURST_DEFAULT = 4;
    localparam int ID_W              = $clog2(N_REQ_DEFAULT);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin search. Returns the first set bit of req,
//   searching start, start+1, ... wrapping modulo N.
//   Ports:
//     req    in   N    request vector
//     start  in   IW   index where the search begins
//     found  out  1    some request bit is set
//     idx    out  IW   chosen index (0 when found=0)
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Walk the offsets from farthest to nearest so the nearest valid
    // request (smallest offset from start) is the last one written.
    always_comb begin
        found = |req;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(start) + k) % N]) begin
                idx = IW'((int'(start) + k) % N);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Shares the single write port of the 8-deep byte FIFO between N_REQ
//   producers using round-robin arbitration with bounded bursts. Every
//   burst is preceded by one arbitration cycle in IDLE. A write is only
//   issued when the FIFO is not full and no read is being accepted, since
//   the FIFO drops a write in a cycle where it accepts a read.
//
//   Optional build macro FIFO_ARB_PRIO_EN: producer 0 becomes urgent. It
//   wins arbitration whenever it is valid, its bursts are one beat long and
//   its grants leave the round-robin pointer where it was.
//
//   Ports:
//     clk            in   1              clock, rising edge
//     reset          in   1              synchronous, active-high
//     req_valid      in   N_REQ          per-producer data valid
//     req_data       in   N_REQ*DATA_W   producer i payload at [i*DATA_W +: DATA_W]
//     req_ready      out  N_REQ          per-producer accept (one-hot or zero)
//     fifo_full      in   1              FIFO full flag
//     fifo_empty     in   1              FIFO empty flag
//     fifo_read_en   in   1              consumer read enable into the FIFO
//     fifo_write_en  out  1              FIFO write enable
//     fifo_data      out  DATA_W         FIFO write data
//     grant_id       out  clog2(N_REQ)   granted producer, valid while busy
//     busy           out  1              high in BURST
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEFAULT,
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      fifo_full,
    input  logic                      fifo_empty,
    input  logic                      fifo_read_en,
    output logic                      fifo_write_en,
    output logic [DATA_W-1:0]         fifo_data,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      busy
);

    localparam int GW = $clog2(N_REQ);

    state_t          state;
    logic [GW-1:0]   rr_ptr;
    logic [3:0]      beat_cnt;

    logic            wr_ok;
    logic            slot_open;
    logic            cur_valid;
    logic            beat;
    logic            urgent;
    logic [3:0]      burst_limit;
    logic            last_beat;
    logic            burst_done;
    logic            pick_found;
    logic [GW-1:0]   pick_idx;
    logic [GW-1:0]   arb_idx;
    logic [GW-1:0]   next_ptr;

    // A write is safe only when the FIFO has room and is not accepting a
    // read in the same cycle. Reset also closes the slot so a beat that
    // coincides with reset is never handed to the FIFO.
    assign wr_ok     = !fifo_full && !(fifo_read_en && !fifo_empty);
    assign busy      = (state == BURST);
    assign slot_open = busy && !reset && wr_ok;
    assign cur_valid = req_valid[grant_id];
    assign beat      = slot_open && cur_valid;

    assign fifo_write_en = beat;
    assign fifo_data     = req_data[32'(grant_id) * DATA_W +: DATA_W];

    // Only the granted producer sees ready, and only when a write can land.
    always_comb begin
        req_ready = '0;
        if (slot_open) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    rr_pick #(
        .N  (N_REQ),
        .IW (GW)
    ) u_rr_pick (
        .req   (req_valid),
        .start (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

`ifdef FIFO_ARB_PRIO_EN
    assign urgent  = (grant_id == '0);
    assign arb_idx = req_valid[0] ? '0 : pick_idx;
`else
    assign urgent  = 1'b0;
    assign arb_idx = pick_idx;
`endif

    // A burst ends on the beat that reaches its limit, or when the granted
    // producer drops valid in a cycle without a beat. A stall (valid held,
    // slot closed) keeps the grant and does not consume burst budget.
    assign burst_limit = urgent ? 4'd1 : 4'(MAX_BURST);
    assign last_beat   = beat && ((beat_cnt + 4'd1) == burst_limit);
    assign burst_done  = last_beat || (!beat && !cur_valid);
    assign next_ptr    = (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

    // Arbitration FSM. IDLE picks a producer when one is valid and a write
    // slot exists; BURST streams beats until the burst ends, then moves the
    // round-robin pointer past the producer just served.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            grant_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found && wr_ok) begin
                        grant_id <= arb_idx;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 4'd1;
                    end
                    if (burst_done) begin
                        state <= IDLE;
                        if (!urgent) begin
                            rr_ptr <= next_ptr;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
